vga_pixel_aligner: RTL

//  Pixel-clock stage between the framebuffer read FIFO and the VGA output pins.
//  - Consumes a valid/ready pixel stream carrying a start-of-frame flag.
//  - Aligns that stream to the timing generator's HS/VS/BLANK.
//  - Drives registered RGB plus timing delayed by 1 cycle.
//  - Detects underflow and frame misalignment, and resynchronises on the next frame.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_pixel_aligner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA types and timing constants
package vga_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    SEEK,
    ARMED,
    STREAM
  } align_state_t;

  // 800x480 panel timing used by the timing generator
  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 88;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 32;

endpackage

// File: rtl/vga_pixel_aligner.sv
// rtl/vga_pixel_aligner.sv - aligns the framebuffer pixel stream to VGA timing
// and drives the registered output pins.
module vga_pixel_aligner
  import vga_pkg::*;
#(
  parameter int   HDISP         = 800,
  parameter int   VDISP         = 480,
  parameter rgb_t UNDERFLOW_RGB = 24'hFF0000
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        tim_hs,
  input  logic        tim_vs,
  input  logic        tim_blank,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic [23:0] s_rgb,
  output logic        s_ready,
  input  logic        err_clr,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_blank,
  output logic [23:0] out_rgb,
  output logic        locked,
  output logic        err_uflow,
  output logic        err_align
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);

  align_state_t   state_q, state_d;
  logic           frame_pend_q, frame_pend_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           out_hs_q, out_hs_d;
  logic           out_vs_q, out_vs_d;
  logic           out_blank_q, out_blank_d;
  rgb_t           out_rgb_q, out_rgb_d;
  logic           err_uflow_q, err_uflow_d;
  logic           err_align_q, err_align_d;

  logic           vs_fall;
  logic           first_px;
  logic           uflow_set;
  logic           align_set;
  logic [XW-1:0]  cur_x;
  logic [YW-1:0]  cur_y;

  // out_vs_q doubles as the previous tim_vs sample for edge detection
  assign vs_fall  = out_vs_q & ~tim_vs;
  assign first_px = tim_blank & (frame_pend_q | vs_fall);

  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      SEEK:    s_ready = s_valid & ~s_sof;
      ARMED:   s_ready = first_px & s_valid;
      STREAM:  s_ready = tim_blank & s_valid & (s_sof == first_px);
      default: s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    frame_pend_d = (frame_pend_q | vs_fall) & ~first_px;
    x_d          = x_q;
    y_d          = y_q;
    cur_x        = first_px ? '0 : x_q;
    cur_y        = first_px ? '0 : y_q;
    uflow_set    = 1'b0;
    align_set    = 1'b0;

    if (tim_blank) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end

    unique case (state_q)
      SEEK: begin
        if (s_valid & s_sof) state_d = ARMED;
      end
      ARMED: begin
        if (first_px) begin
          if (s_valid) begin
            state_d = STREAM;
          end else begin
            uflow_set = 1'b1;
            state_d   = SEEK;
          end
        end
      end
      STREAM: begin
        if (tim_blank) begin
          if (!s_valid) begin
            uflow_set = 1'b1;
            state_d   = SEEK;
          end else if (s_sof != first_px) begin
            // A mismatched SOF is kept so it can start the next frame
            align_set = 1'b1;
            state_d   = s_sof ? ARMED : SEEK;
          end
        end
      end
      default: state_d = SEEK;
    endcase

    out_hs_d    = tim_hs;
    out_vs_d    = tim_vs;
    out_blank_d = tim_blank;
    // Beats dropped while seeking are never displayed
    if (!tim_blank)
      out_rgb_d = '0;
    else if (s_ready && state_q != SEEK)
      out_rgb_d = s_rgb;
    else
      out_rgb_d = UNDERFLOW_RGB;

    err_uflow_d = uflow_set | (err_uflow_q & ~err_clr);
    err_align_d = align_set | (err_align_q & ~err_clr);
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q      <= SEEK;
      frame_pend_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      out_hs_q     <= 1'b1;
      out_vs_q     <= 1'b1;
      out_blank_q  <= 1'b0;
      out_rgb_q    <= '0;
      err_uflow_q  <= 1'b0;
      err_align_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_pend_q <= frame_pend_d;
      x_q          <= x_d;
      y_q          <= y_d;
      out_hs_q     <= out_hs_d;
      out_vs_q     <= out_vs_d;
      out_blank_q  <= out_blank_d;
      out_rgb_q    <= out_rgb_d;
      err_uflow_q  <= err_uflow_d;
      err_align_q  <= err_align_d;
    end
  end

  assign out_hs    = out_hs_q;
  assign out_vs    = out_vs_q;
  assign out_blank = out_blank_q;
  assign out_rgb   = out_rgb_q;
  assign locked    = (state_q == STREAM);
  assign err_uflow = err_uflow_q;
  assign err_align = err_align_q;

endmodule
